reg_file: RTL
=============

Name: reg_file

Overview:
- Architectural integer register file for the single-cycle processor.
- Sits directly downstream of the write-back select mux (ALU result vs. load data): the mux output drives wr_data.
- Provides two combinational read ports feeding the ALU operand path and one clocked write port.
- Includes a debug read port and a retired-write counter for bring-up.

Parameters:
- N, 32, data width of each register.
- ADDR_W, 5, register address width.
- DEPTH, 32, number of registers (must equal 2**ADDR_W).
- CNT_W, 32, width of the write counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rd_addr  input  ADDR_W  write address.
- wr_data  input  N  write data (from the write-back mux).
- reg_write  input  1  write enable.
- rs1_data  output  N  read port 1 data.
- rs2_data  output  N  read port 2 data.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  N  debug read data.
- wr_count  output  CNT_W  count of committed writes.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - On a reset edge, all DEPTH registers clear to 0 and wr_count clears to 0.
  - Reset has priority: a write presented in the same cycle is discarded and not counted.
  - Reset asserted mid-program clears state on that edge only; normal operation resumes on the first edge with reset=0.
- Reads: rs1_data, rs2_data and dbg_data are purely combinational (zero latency) from the register array.
  - Any read of address 0 returns 0.
- Writes: on a rising edge with reset=0, reg_write=1 and rd_addr!=0, wr_data is stored at rd_addr and wr_count increments by 1.
  - Writes to address 0 are ignored and do not increment wr_count.
  - The new value is visible on the read ports after the edge (read-old-value within the same cycle, unless the optional feature is enabled).
- Counter: wr_count wraps modulo 2**CNT_W, with no saturation.
- Simultaneous events:
  - Both read ports and the debug port may address the same register as each other or as rd_addr; all return consistent data.
  - reg_write=1 with X on rd_addr is a testbench error; there is no RTL protection.
- Register 0: never holds a nonzero value, even though storage may be allocated.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: write-through bypass. If reg_write=1, rd_addr!=0 and a read address equals rd_addr, that read port returns wr_data in the same cycle. Applies to rs1, rs2 and dbg.
- Undefined: reads return the stored (pre-edge) value.
- The bypass is suppressed while reset=1; the read returns the stored value.

Decomposition:
- Shared package reg_file_pkg:
  - ADDR_W and DEPTH constants.
  - ZERO_REG constant = 0.
  - typedef reg_addr_t (ADDR_W bits).
  - typedef reg_data_t (N bits).
- One sub-module is natural: reg_file_rd_port.
  - Handles address decode, the zero-register force and the optional bypass compare.
  - Instantiated three times (rs1, rs2, dbg).
- Storage, write logic and the counter stay in reg_file.

Test Plan:
- Reset clears state: write 0xDEADBEEF to x5, then assert reset for 1 cycle → rs1_addr=5 reads 0, wr_count=0.
- Basic write/read: write x1=0x12345678, x31=0xFFFFFFFF; set rs1_addr=1, rs2_addr=31 → 0x12345678 and 0xFFFFFFFF; wr_count=2.
- Register 0 is immutable: reg_write=1, rd_addr=0, wr_data=0xAAAAAAAA → rs1_addr=0 reads 0; wr_count unchanged.
- Same-cycle read of the target:
  - x7 holds 0x1; write x7=0x2 with rs1_addr=7.
  - Pre-edge read returns 0x1 without REG_FILE_BYPASS_EN, 0x2 with it.
  - Post-edge read returns 0x2 in both builds.
- Reset collides with a write: reset=1, reg_write=1, rd_addr=3, wr_data=0x55 → x3=0 and wr_count=0 after the edge.
- Counter wrap: CNT_W=4 build, 17 valid writes → wr_count=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural integer register file.
package reg_file_pkg;

    localparam int N        = 32;
    localparam int ADDR_W   = 5;
    localparam int DEPTH    = 32;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [N-1:0]      reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port of the register file: address decode,
// register 0 forced to zero, and the write-through bypass compare when
// REG_FILE_BYPASS_EN is defined.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int N      = reg_file_pkg::N,
    parameter int ADDR_W = reg_file_pkg::ADDR_W,
    parameter int DEPTH  = reg_file_pkg::DEPTH
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [N-1:0]      regs [DEPTH],
    input  logic              reg_write,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      wr_data,
    output logic [N-1:0]      data
);

`ifndef REG_FILE_BYPASS_EN
    // The bypass inputs only matter when the forwarding path is built.
    logic unused_bypass;
    assign unused_bypass = &{1'b0, reset, reg_write, rd_addr, wr_data};
`endif

    // Select the stored value, forward the in-flight write if enabled, and
    // keep register 0 reading as zero regardless of storage contents.
    always_comb begin
        data = '0;
        if (addr != ADDR_W'(ZERO_REG)) begin
            data = regs[addr];
`ifdef REG_FILE_BYPASS_EN
            if (!reset && reg_write && (rd_addr != ADDR_W'(ZERO_REG)) &&
                (rd_addr == addr)) begin
                data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural integer register file: two operand read ports, one debug
// read port, one clocked write port and a retired-write counter.
// Optional macro REG_FILE_BYPASS_EN enables same-cycle write-through to reads.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int N      = reg_file_pkg::N,
    parameter int ADDR_W = reg_file_pkg::ADDR_W,
    parameter int DEPTH  = reg_file_pkg::DEPTH,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [N-1:0]      wr_data,
    input  logic              reg_write,
    output logic [N-1:0]      rs1_data,
    output logic [N-1:0]      rs2_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [N-1:0]      dbg_data,
    output logic [CNT_W-1:0]  wr_count
);

    logic [N-1:0] regs [DEPTH];
    logic         write_ok;

    assign write_ok = reg_write && (rd_addr != ADDR_W'(ZERO_REG));

    // Storage and write counter; reset wins over a coincident write, and
    // writes to register 0 are dropped so it never holds a nonzero value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (write_ok) begin
            regs[rd_addr] <= wr_data;
            wr_count      <= wr_count + CNT_W'(1);
        end
    end

    reg_file_rd_port #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rs1 (
        .reset     (reset),
        .addr      (rs1_addr),
        .regs      (regs),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .data      (rs1_data)
    );

    reg_file_rd_port #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rs2 (
        .reset     (reset),
        .addr      (rs2_addr),
        .regs      (regs),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .data      (rs2_data)
    );

    reg_file_rd_port #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dbg (
        .reset     (reset),
        .addr      (dbg_addr),
        .regs      (regs),
        .reg_write (reg_write),
        .rd_addr   (rd_addr),
        .wr_data   (wr_data),
        .data      (dbg_data)
    );

endmodule
